mem_req_ctrl: RTL and testbench

- Request/response front end that sits directly upstream of the banked 16-bit single-port synchronous main-memory array.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences the RAM's cs/we/oe strobes and drives or releases the shared inout data bus.
- Returns exactly one response per request over a second valid/ready handshake.

---
 rtl/mem_req_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
//
// Purpose:
//   Request/response front end for the banked single-port synchronous main
//   memory array. Takes one read or write request at a time, sequences the
//   RAM cs/we/oe strobes, owns or releases the shared data bus, and returns
//   exactly one response per request.
//
// Optional feature (macro MEM_CTRL_WR_VERIFY_EN):
//   When defined, every write is followed by a two-cycle read-back (VR1/VR2).
//   resp_err reports whether the word read back differs from the written
//   word. When undefined, resp_err is tied low.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   req_valid  - request present
//   req_ready  - controller can accept a request (IDLE only)
//   req_we     - 1 = write, 0 = read
//   req_addr   - request word address
//   req_wdata  - write data
//   resp_valid - response present
//   resp_ready - consumer takes the response
//   resp_rdata - read data, 0 for write responses
//   resp_err   - write-verify mismatch flag
//   mem_addr   - RAM address
//   mem_data   - shared RAM data bus (inout)
//   mem_cs     - RAM chip select
//   mem_we     - RAM write enable
//   mem_oe     - RAM output enable
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

`ifdef MEM_CTRL_WR_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4,
        VR1  = 3'd5,
        VR2  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4
    } state_t;
`endif

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  bus_drive;

    // The request direction is not kept in its own register: it is fully
    // encoded by the WR vs RD1 branch taken out of IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_we ? WR : RD1;
                end
            end
`ifdef MEM_CTRL_WR_VERIFY_EN
            WR:   state_next = VR1;
            VR1:  state_next = VR2;
            VR2:  state_next = RESP;
`else
            WR:   state_next = RESP;
`endif
            RD1:  state_next = RD2;
            RD2:  state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode from the registered state. Reset masks them
    // combinationally so a WR cycle coinciding with reset never writes and
    // the bus is released immediately.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_oe     = 1'b0;
        bus_drive  = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                bus_drive = 1'b1;
            end
`ifdef MEM_CTRL_WR_VERIFY_EN
            RD1, RD2, VR1, VR2: begin
`else
            RD1, RD2: begin
`endif
                mem_cs = 1'b1;
                mem_oe = 1'b1;
            end
            RESP: resp_valid = 1'b1;
            default: ;
        endcase
        if (rst) begin
            mem_cs    = 1'b0;
            mem_we    = 1'b0;
            mem_oe    = 1'b0;
            bus_drive = 1'b0;
        end
    end

    assign mem_data   = bus_drive ? lat_wdata : {DATA_WIDTH{1'bz}};
    assign mem_addr   = lat_addr;
    assign resp_rdata = rdata_q;

`ifdef MEM_CTRL_WR_VERIFY_EN
    logic err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // State register, request latch and response capture. The RAM output is
    // registered at the end of RD1, so the word is stable on the bus during
    // RD2 and is captured at the end of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
`ifdef MEM_CTRL_WR_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                    end
                end
                RD2: rdata_q <= mem_data;
`ifdef MEM_CTRL_WR_VERIFY_EN
                VR2: err_q <= (mem_data != lat_wdata);
`endif
                RESP: begin
                    if (resp_ready) begin
                        rdata_q <= '0;
`ifdef MEM_CTRL_WR_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
//
// Self-checking bench for mem_req_ctrl with a behavioural synchronous RAM on
// the shared data bus. Expected responses are queued when a request is
// accepted; a monitor compares them when the DUT presents a response.
// ---------------------------------------------------------------------------
module tb_mem_req_ctrl;

    localparam int AW = 14;
    localparam int DW = 16;
`ifdef MEM_CTRL_WR_VERIFY_EN
    localparam int WR_LAT = 4;
    localparam bit VERIFY = 1'b1;
`else
    localparam int WR_LAT = 2;
    localparam bit VERIFY = 1'b0;
`endif
    localparam int RD_LAT = 3;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
        string         name;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_hs_cyc = -1;
    int overlap_count = 0;
    bit in_resp = 1'b0;

    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe)
    );

    // Behavioural RAM: write and read-register on the clock edge, output
    // driven onto the bus while cs and oe are high. stuck_bit4 forces data
    // bit 4 to 0 on writes to model a faulty cell.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_dout;
    logic          stuck_bit4;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram_dout = '0;
    end

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_data & (stuck_bit4 ? 16'hFFEF : 16'hFFFF);
            else        ram_dout <= ram[mem_addr];
        end
    end

    assign mem_data = (mem_cs && mem_oe) ? ram_dout : {DW{1'bz}};

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents a request and holds it until accepted; returns one tick after
    // the accept edge, i.e. at the start of the first post-accept cycle.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input bit expect_resp, input logic [DW-1:0] exp_rdata,
                                 input logic exp_err, input string name);
        bit   accepted;
        exp_t e;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready && !rst) begin
                accepted   = 1'b1;
                accept_cyc = cyc;
                if (expect_resp) begin
                    e.rdata = exp_rdata;
                    e.err   = exp_err;
                    e.due   = cyc + (we ? WR_LAT : RD_LAT);
                    e.name  = name;
                    exp_q.push_back(e);
                end
            end
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_accept: got no accept expected accept within 60 cycles", name);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !resp_valid) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_drain: got %0d pending expected 0 pending", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: checks latency and content on the first cycle a
    // response is shown, stability while it is held, and pops on handshake.
    always @(negedge clk) begin
        if (mem_we && mem_oe) overlap_count++;
        if (rst) begin
            in_resp = 1'b0;
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else if (!in_resp) begin
                checkOutput({exp_q[0].name, "_latency"}, 32'(cyc), 32'(exp_q[0].due));
                checkOutput({exp_q[0].name, "_rdata"}, 32'(resp_rdata), 32'(exp_q[0].rdata));
                checkOutput({exp_q[0].name, "_err"}, 32'(resp_err), 32'(exp_q[0].err));
            end else begin
                checkOutput({exp_q[0].name, "_held_rdata"}, 32'(resp_rdata), 32'(exp_q[0].rdata));
                checkOutput({exp_q[0].name, "_held_err"}, 32'(resp_err), 32'(exp_q[0].err));
            end
            in_resp = 1'b1;
            if (resp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                in_resp     = 1'b0;
                last_hs_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int resp_seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        stuck_bit4 = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_mem_cs", 32'(mem_cs), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_oe", 32'(mem_oe), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_rdata", 32'(resp_rdata), 32'd0);
        checkOutput("rst_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic write then read.
        applyStimulus(1'b1, 14'h0005, 16'h1234, 1'b1, 16'h0000, 1'b0, "wr5");
        waitDrain("wr5");
        applyStimulus(1'b0, 14'h0005, 16'h0000, 1'b1, 16'h1234, 1'b0, "rd5");
        waitDrain("rd5");

        // Top bank and bank 0, no aliasing.
        applyStimulus(1'b1, 14'h3FFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, "wrTop");
        waitDrain("wrTop");
        applyStimulus(1'b1, 14'h0000, 16'hA5A5, 1'b1, 16'h0000, 1'b0, "wrZero");
        waitDrain("wrZero");
        applyStimulus(1'b0, 14'h3FFF, 16'h0000, 1'b1, 16'hFFFF, 1'b0, "rdTop");
        waitDrain("rdTop");
        applyStimulus(1'b0, 14'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, "rdZero");
        waitDrain("rdZero");

        // Backpressure: response held, second request waits for handshake.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 14'h0005, 16'h0000, 1'b1, 16'h1234, 1'b0, "rdBp");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 14'h0020;
        req_wdata = 16'h0777;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            if (i >= 2) checkOutput("bp_mem_cs", 32'(mem_cs), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        applyStimulus(1'b1, 14'h0020, 16'h0777, 1'b1, 16'h0000, 1'b0, "wrAfterBp");
        checkOutput("bp_accept_cycle", 32'(accept_cyc), 32'(last_hs_cyc + 1));
        waitDrain("wrAfterBp");

        // Reset held 3 cycles starting in RD1 of a read.
        applyStimulus(1'b0, 14'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, "rdAbortA");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstMid_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("rstMid_mem_cs", 32'(mem_cs), 32'd0);
            checkOutput("rstMid_mem_oe", 32'(mem_oe), 32'd0);
            if (i > 0) checkOutput("rstMid_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstRelease_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset in RD2 of a read: no response.
        applyStimulus(1'b0, 14'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, "rdAbortB");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstRd2_mem_cs", 32'(mem_cs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        checkOutput("rstRd2_no_resp", 32'(resp_seen), 32'd0);
        @(posedge clk);
        #1;

        // Reset in WR of a write: nothing written, no response.
        applyStimulus(1'b1, 14'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, "wrAbort");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstWr_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        checkOutput("rstWr_no_resp", 32'(resp_seen), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 14'h0010, 16'h0000, 1'b1, 16'h0000, 1'b0, "rd10");
        waitDrain("rd10");

        // Write verify with a stuck-at-0 bit 4, then clean.
        stuck_bit4 = 1'b1;
        applyStimulus(1'b1, 14'h0030, 16'h00F0, 1'b1, 16'h0000, VERIFY, "wrFault");
        waitDrain("wrFault");
        stuck_bit4 = 1'b0;
        applyStimulus(1'b0, 14'h0030, 16'h0000, 1'b1, 16'h00E0, 1'b0, "rdFault");
        waitDrain("rdFault");
        applyStimulus(1'b1, 14'h0030, 16'h00F0, 1'b1, 16'h0000, 1'b0, "wrClean");
        waitDrain("wrClean");
        applyStimulus(1'b0, 14'h0030, 16'h0000, 1'b1, 16'h00F0, 1'b0, "rdClean");
        waitDrain("rdClean");

        checkOutput("we_oe_overlap", 32'(overlap_count), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
